lsu_ctrl: RTL

Load/store controller that sits between the CPU datapath and the 1 KiB byte-addressed data memory (`dm_1k`). It is the initiating side of that memory port. It accepts one load or store request at a time over a valid/ready handshake and checks size and alignment. It drives the memory's `addr`/`din`/`we`/`sb` strobes, splitting halfword stores into two byte writes, and returns sign- or zero-extended load data on a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_load_ext.sv | 30 +++
 rtl/lsu_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and the size/alignment check for the
// load/store controller.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR0,
        WR1,
        RESP
    } lsu_state_t;

    // True when the size is illegal or the low address bits break alignment.
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extractor: picks the low byte/half of the memory
// word and sign- or zero-extends it; words pass straight through.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        ext  = dout;
        case (size)
            SZ_BYTE: begin
                fill = ~is_unsigned & dout[7];
                ext  = {{24{fill}}, dout[7:0]};
            end
            SZ_HALF: begin
                fill = ~is_unsigned & dout[15];
                ext  = {{16{fill}}, dout[15:0]};
            end
            default: ext = dout;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, size/alignment checking,
// halfword stores split into two byte writes, extended load data on a pulse.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    output logic              mem_sb,
    input  logic [31:0]       mem_dout
);

    lsu_state_t        state_reg, state_next;
    logic              we_reg;
    logic              uns_reg;
    logic              err_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg;
    logic [31:0]       ext_data;
    logic              accept;
    logic              req_err;

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_err   = align_err(req_size, req_addr[1:0]) || ((req_addr >> ADDR_W) != 32'd0);

    lsu_load_ext u_load_ext (
        .dout        (mem_dout),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .ext         (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            err_reg   <= 1'b0;
            size_reg  <= SZ_BYTE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg    <= req_we;
                uns_reg   <= req_unsigned;
                err_reg   <= req_err;
                size_reg  <= req_size;
                addr_reg  <= req_addr[ADDR_W-1:0];
                wdata_reg <= req_wdata;
                // Stores and rejected requests report zero data.
                rdata_reg <= '0;
            end else if (state_reg == RD) begin
                rdata_reg <= ext_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_err)     state_next = RESP;
                    else if (req_we) state_next = WR0;
                    else             state_next = RD;
                end
            end
            RD:      state_next = RESP;
            WR0:     state_next = (size_reg == SZ_HALF) ? WR1 : RESP;
            WR1:     state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write strobes are qualified by rst_n so a reset cycle never writes.
    always_comb begin
        mem_addr  = addr_reg;
        mem_din   = '0;
        mem_we    = 1'b0;
        mem_sb    = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state_reg)
            WR0: begin
                if (size_reg == SZ_WORD) begin
                    mem_we  = rst_n;
                    mem_din = wdata_reg;
                end else begin
                    mem_sb  = rst_n;
                    mem_din = {24'd0, wdata_reg[7:0]};
                end
            end
            WR1: begin
                mem_sb   = rst_n;
                mem_addr = addr_reg + ADDR_W'(1);
                mem_din  = {24'd0, wdata_reg[15:8]};
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_reg;
                rsp_rdata = rdata_reg;
            end
            default: ;
        endcase
    end

    logic unused_we;
    assign unused_we = we_reg;

endmodule
